spi_reg_ctrl: RTL

Register-access controller that sits above the byte-level SPI slave and turns its received byte stream into register-bank reads and writes. It decodes a command byte per chip-select frame and issues single-cycle write or read strobes to a local register bus. On reads it returns data through the slave's transmit byte. It is the only master of the control register bank, so host MCU configuration always goes through this block.

---
 rtl/spi_reg_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: turns the SPI slave's byte stream into register-bank
// reads and writes. One command byte per chip-select frame selects the
// direction (bit7=1 read) and the start address; following bytes are write
// data or dummy bytes that clock out read data.
//
// Build option: define SPI_REG_AUTOINC_EN to advance the address after each
// write commit / read fetch (burst access). Left undefined, the address holds
// the command value for the whole frame (streaming to a single register).
//
// Handshake semantics: byte_done is a one-cycle qualifier for rx_byte and no
// backpressure exists; reg_we and reg_re are single-cycle strobes with
// reg_addr/reg_wdata valid in the same cycle, and reg_rdata is sampled
// exactly one cycle after reg_re.
module spi_reg_ctrl #(
  parameter int         ADDR_W    = 7,
  parameter int         REG_NUM   = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cs,
  input  logic              byte_done,
  input  logic [7:0]        rx_byte,
  output logic [7:0]        tx_byte,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy,
  output logic              frame_done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    WR      = 3'd2,
    RD_REQ  = 3'd3,
    RD_WAIT = 3'd4,
    RD_DATA = 3'd5
  } state_t;

  // One extra bit so REG_NUM == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W+1)'(REG_NUM);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt, addr_step, cmd_addr;
  logic [7:0]        tx_nxt, wdata_nxt;
  logic [ADDR_W-1:0] reg_addr_nxt;
  logic              we_nxt, re_nxt, err_nxt;
  logic              cs_q, cs_fall, cs_rise, seen_byte;
  logic              addr_ok;

  assign cmd_addr = rx_byte[ADDR_W-1:0];
  assign addr_ok  = ({1'b0, addr} < REG_LIMIT);
  assign cs_fall  = cs_q & ~cs;
  assign cs_rise  = ~cs_q & cs;
  assign busy     = (state != IDLE);
  assign dbg_state = state;

`ifdef SPI_REG_AUTOINC_EN
  assign addr_step = addr + ADDR_W'(1);
`else
  assign addr_step = addr;
`endif

  // State, address and registered bus outputs.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      addr      <= '0;
      tx_byte   <= SYNC_BYTE;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      tx_byte   <= tx_nxt;
      reg_addr  <= reg_addr_nxt;
      reg_wdata <= wdata_nxt;
      reg_we    <= we_nxt;
      reg_re    <= re_nxt;
      err       <= err_nxt;
    end
  end

  // Next-state decode and next values for the registered outputs.
  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr;
    tx_nxt       = tx_byte;
    reg_addr_nxt = reg_addr;
    wdata_nxt    = reg_wdata;
    we_nxt       = 1'b0;
    re_nxt       = 1'b0;
    err_nxt      = err;
    case (state)
      IDLE: begin
        if (!cs) begin
          state_nxt = CMD;
          tx_nxt    = SYNC_BYTE;
        end
      end
      CMD: begin
        if (byte_done) begin
          addr_nxt = cmd_addr;
          if (rx_byte[7]) begin
            state_nxt    = RD_REQ;
            re_nxt       = 1'b1;
            reg_addr_nxt = cmd_addr;
          end else begin
            state_nxt = WR;
          end
        end
      end
      WR: begin
        // A byte arriving with the cs rise is still committed.
        if (byte_done) begin
          reg_addr_nxt = addr;
          wdata_nxt    = rx_byte;
          addr_nxt     = addr_step;
          if (addr_ok) we_nxt  = 1'b1;
          else         err_nxt = 1'b1;
        end
      end
      RD_REQ: begin
        state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        tx_nxt    = addr_ok ? reg_rdata : 8'h00;
        if (!addr_ok) err_nxt = 1'b1;
        addr_nxt  = addr_step;
        state_nxt = RD_DATA;
      end
      RD_DATA: begin
        if (byte_done) begin
          state_nxt    = RD_REQ;
          re_nxt       = 1'b1;
          reg_addr_nxt = addr;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Deselect ends the frame; no read is launched once cs is high.
    if (cs) begin
      state_nxt = IDLE;
      re_nxt    = 1'b0;
    end
    if (cs_fall) err_nxt = 1'b0;
  end

  // Chip-select edge tracking and end-of-frame pulse.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cs_q       <= 1'b1;
      seen_byte  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      cs_q       <= cs;
      frame_done <= cs_rise & (seen_byte | byte_done);
      if (cs_fall) seen_byte <= 1'b0;
      else if (byte_done) seen_byte <= 1'b1;
    end
  end

endmodule
